// File: rtl/fir_job_ctrl.sv
// fir_job_ctrl: job sequencer for the FIR datapath.
// A job clears the datapath, admits one coefficient beat, admits len_i x beats,
// and waits for len_i y beats before it pulses done. The block drives only the
// stream enables and the datapath clear. It observes the handshakes and never
// touches stream data.
module fir_job_ctrl #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 h_en_o,
  output logic                 x_en_o,
  output logic                 y_en_o,
  output logic                 clear_o,
  input  logic                 h_hs_i,
  input  logic                 x_hs_i,
  input  logic                 y_hs_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] x_cnt_o,
  output logic [LEN_WIDTH-1:0] y_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_H,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] x_cnt_q, x_cnt_d;
  logic [LEN_WIDTH-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 h_en_q, h_en_d;
  logic                 x_en_q, x_en_d;
  logic                 y_en_q, y_en_d;
  logic                 clear_q, clear_d;
  logic                 done_q, done_d;

  // A handshake counts only while its gate is open. The gates are the
  // registered enables, so they match what the stream gates see this cycle.
  logic h_fire, x_fire, y_fire;
  assign h_fire = h_en_q & h_hs_i;
  assign x_fire = x_en_q & x_hs_i;
  assign y_fire = y_en_q & y_hs_i;

  // Next-state, counter and registered-output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that leaves
    // a signal unassigned would infer a latch.
    state_d = state_q;
    len_d   = len_q;
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    stall_d = stall_q;
    clear_d = 1'b0;

    // Beat and stall accounting while the job streams.
    if (state_q == S_STREAM || state_q == S_DRAIN) begin
      if (x_fire) begin
        x_cnt_d = x_cnt_q + LEN_WIDTH'(1);
      end
      if (y_fire) begin
        y_cnt_d = y_cnt_q + LEN_WIDTH'(1);
      end
      if (!x_fire && !y_fire && stall_q != '1) begin
        stall_d = stall_q + CNT_WIDTH'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          x_cnt_d = '0;
          y_cnt_d = '0;
          stall_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD_H;
      end
      S_LOAD_H: begin
        // An empty job still consumes its coefficient beat, then finishes.
        if (h_fire) begin
          state_d = (len_q == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        // On the last x beat, skip DRAIN if every y beat has already left.
        if (x_fire && x_cnt_d == len_q) begin
          state_d = (y_cnt_d == len_q) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (y_cnt_d == len_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any normal transition. Counters keep the values they
    // held when the abort was seen, and the datapath gets a clear pulse.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      stall_d = stall_q;
      clear_d = 1'b1;
    end

    // Outputs are decoded from the next state and registered, so each change
    // appears together with the state it belongs to.
    h_en_d  = (state_d == S_LOAD_H);
    x_en_d  = (state_d == S_STREAM);
    y_en_d  = (state_d == S_STREAM) || (state_d == S_DRAIN);
    clear_d = clear_d || (state_d == S_CLEAR);
    done_d  = (state_d == S_DONE);
  end

  // State, counters and output registers. Synchronous reset clears everything.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      stall_q <= '0;
      h_en_q  <= 1'b0;
      x_en_q  <= 1'b0;
      y_en_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      stall_q <= stall_d;
      h_en_q  <= h_en_d;
      x_en_q  <= x_en_d;
      y_en_q  <= y_en_d;
      clear_q <= clear_d;
      done_q  <= done_d;
    end
  end

  assign h_en_o      = h_en_q;
  assign x_en_o      = x_en_q;
  assign y_en_o      = y_en_q;
  assign clear_o     = clear_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);
  assign x_cnt_o     = x_cnt_q;
  assign y_cnt_o     = y_cnt_q;
  assign stall_cnt_o = stall_q;

endmodule
